resp_rx_host: RTL

//  Host-side receive end of the command/response link. Deserializes 8N1 response bytes from the
//  DUT UART TX line (ack 8'hA5, register reads, channel dumps). Collects an armed number of dump

---
 rtl/resp_rx_host.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/resp_rx_host.sv
// resp_rx_host: receives 8N1 response bytes from the DUT UART TX line and captures an
// armed number of them into a read-back buffer.
// Latency: rdy and rx_data update 1 clk after the stop-bit mid-sample; rd_data is registered (1 clk).
// Backpressure: none. A new byte overwrites rx_data even if rdy is still set; the host clears rdy with clr_rdy.
// Ports: clk/rst_n; RX serial in; baud_cnt clks per bit; start/exp_cnt arm a capture;
//        rx_data/rdy/clr_rdy last-byte handshake; frame_err/byte_cnt/done/timeout capture status;
//        rd_addr/rd_data buffer read port.
module resp_rx_host #(
   parameter int ENTRIES = 384,
   parameter int LOG2    = 9,
   parameter int TIMEOUT = 200000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            RX,
   input  logic [15:0]     baud_cnt,
   input  logic            start,
   input  logic [LOG2:0]   exp_cnt,
   output logic [7:0]      rx_data,
   output logic            rdy,
   input  logic            clr_rdy,
   output logic            frame_err,
   output logic [LOG2:0]   byte_cnt,
   output logic            done,
   output logic            timeout,
   input  logic [LOG2-1:0] rd_addr,
   output logic [7:0]      rd_data
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        state, state_nxt;
   logic          rx_s1, rx_s2, rx_d;
   logic [15:0]   timer, baud_lat;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          armed;
   logic [LOG2:0] exp_lat, exp_clamp, cnt_inc;
   logic [TW-1:0] tcnt;
   logic          fall, tick, start_det, good_byte, bad_byte, store;

   // The buffer is sized to the full address space so that any rd_addr is a legal read.
   logic [7:0]    mem [2**LOG2];

   assign fall      = rx_d & ~rx_s2;
   assign tick      = (timer == 16'd1);
   assign start_det = (state == S_IDLE) && fall;
   assign good_byte = (state == S_STOP) && tick && rx_s2;
   assign bad_byte  = (state == S_STOP) && tick && !rx_s2;
   // A start pulse in the same clk as a store re-arms the capture and drops the byte.
   assign store     = good_byte && armed && !start;
   assign cnt_inc   = byte_cnt + 1'b1;
   assign exp_clamp = (exp_cnt > (LOG2+1)'(ENTRIES)) ? (LOG2+1)'(ENTRIES) : exp_cnt;

   // Synchronizer and edge-detect flops preset to idle-high so reset never fakes a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= RX;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (fall) state_nxt = S_START;
         S_START: if (tick) state_nxt = rx_s2 ? S_IDLE : S_DATA;
         S_DATA:  if (tick && bit_idx == 3'd7) state_nxt = S_STOP;
         S_STOP:  if (tick) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bit timer counts down and fires when it reaches 1; the first load is half a bit
   // so every later sample lands mid-bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer    <= '0;
         baud_lat <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         if (start_det) begin
            timer    <= baud_cnt >> 1;
            baud_lat <= baud_cnt;
         end else if (state != S_IDLE) begin
            timer <= tick ? baud_lat : timer - 16'd1;
         end
         if (state == S_START && tick) bit_idx <= '0;
         if (state == S_DATA && tick) begin
            shift   <= {rx_s2, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data   <= '0;
         rdy       <= 1'b0;
         frame_err <= 1'b0;
         byte_cnt  <= '0;
         done      <= 1'b0;
         timeout   <= 1'b0;
         armed     <= 1'b0;
         exp_lat   <= '0;
         tcnt      <= '0;
      end else begin
         if (good_byte) begin
            rx_data <= shift;
            rdy     <= 1'b1;
         end else if (clr_rdy || start_det) begin
            rdy <= 1'b0;
         end

         if (start) frame_err <= 1'b0;
         if (bad_byte) frame_err <= 1'b1;

         if (start) begin
            byte_cnt <= '0;
            done     <= (exp_cnt == '0);
            timeout  <= 1'b0;
            exp_lat  <= exp_clamp;
            armed    <= (exp_cnt != '0);
         end else if (store) begin
            byte_cnt <= cnt_inc;
            if (cnt_inc == exp_lat) begin
               done  <= 1'b1;
               armed <= 1'b0;
            end
         end else if (armed && state == S_IDLE && tcnt == TW'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            armed   <= 1'b0;
         end

         // Idle-time watchdog: only line silence while armed counts toward the abort.
         if (start || start_det) tcnt <= '0;
         else if (armed && state == S_IDLE)
            tcnt <= (tcnt == TW'(TIMEOUT - 1)) ? '0 : tcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (store) mem[byte_cnt[LOG2-1:0]] <= shift;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= '0;
      else        rd_data <= mem[rd_addr];
   end

endmodule
